wb_spi_arbiter: RTL and testbench
=================================

# wb_spi_arbiter

Two-master Wishbone arbiter placed in front of the Wishbone-to-SPI bridge (the `top` slave driving the M25AA010A EEPROM). It lets two bus masters share the single bridge slave port: round-robin grant, grant held for a whole CYC cycle, and a watchdog that terminates a stalled access with an error strobe. All slave-side traffic is routed combinationally from the current owner; only arbitration and the watchdog are registered.

## Interface
- `TIMEOUT`, default 255: cycles of STB-without-ACK before the access is aborted; 0 disables the watchdog.
- `TO_W`, default 8: watchdog counter width; must satisfy TIMEOUT < 2^TO_W.
- `CLK_I`  in  1  system clock; all state changes on the rising edge.
- `RST_I`  in  1  reset; asynchronous, active-high.
- `M0_ADR_I`, `M1_ADR_I`  in  8  master address.
- `M0_DAT_I`, `M1_DAT_I`  in  32  master write data.
- `M0_WE_I`, `M1_WE_I`  in  1  write enable.
- `M0_CYC_I`, `M1_CYC_I`  in  1  bus request / cycle valid.
- `M0_STB_I`, `M1_STB_I`  in  1  strobe.
- `M0_DAT_O`, `M1_DAT_O`  out  32  read data; both are a copy of `S_DAT_I`.
- `M0_ACK_O`, `M1_ACK_O`  out  1  acknowledge to the owner only.
- `M0_ERR_O`, `M1_ERR_O`  out  1  one-cycle watchdog abort.
- `S_ADR_O`  out  8, `S_DAT_O`  out  32, `S_WE_O`, `S_CYC_O`, `S_STB_O`  out  1: bridge-side bus.
- `S_DAT_I`  in  32, `S_ACK_I`  in  1: bridge response.
- `GNT_O`  out  2  one-hot current owner (bit0 = M0); 00 when idle.

## Operation
- States: IDLE, OWN0, OWN1. Register `ptr` (0 = M0 preferred, 1 = M1 preferred).
- IDLE: when exactly one CYC is high, go to that master's OWN state. When both are high, go to OWN[ptr]. When neither is high, stay.
- OWNx: stay while `Mx_CYC_I` = 1. On an edge where `Mx_CYC_I` = 0:
  - set `ptr` to the other master;
  - go straight to the other OWN state if its CYC is high (no idle gap);
  - otherwise go to IDLE.
- Routing in OWNx: `S_ADR_O/S_DAT_O/S_WE_O/S_CYC_O/S_STB_O` = Mx inputs. Exception: `S_STB_O` is forced to 0 in the abort cycle.
- `Mx_ACK_O` = `S_ACK_I & Mx_STB_I & OWNx`. The non-owner's ACK/ERR are always 0.
- In IDLE all `S_*` outputs are 0.
- Watchdog (TIMEOUT > 0): counter `to_cnt` behaviour per edge in OWNx:
  - increments while owner STB = 1 and `S_ACK_I` = 0;
  - clears on ACK, on STB = 0, and on any state change.
- Abort: when `to_cnt` == TIMEOUT - 1 and still no ACK, the next cycle is the abort cycle:
  - `Mx_ERR_O` = 1, `S_STB_O` = 0, `Mx_ACK_O` = 0;
  - the counter clears and ownership is kept.
- An ACK arriving in the abort cycle is dropped.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, `ptr` = 0, `to_cnt` = 0;
  - `GNT_O` = 00, all `S_*` outputs 0, all ACK/ERR 0;
  - `M*_DAT_O` follow `S_DAT_I`.
- Reset mid-access drops the access. No ACK or ERR is issued for it.
- Grant latency: CYC rising at edge k → owner registered at edge k+1. Slave sees the request in cycle k+1.
- ACK path: combinational, zero added latency after grant.
- Release: CYC low sampled at edge n → `GNT_O` changes at edge n+1. The other master is served from cycle n+1 if it was requesting.
- Abort: ERR asserts in the cycle after TIMEOUT consecutive STB-high/ACK-low cycles, i.e. TIMEOUT+1 cycles after STB first seen by the slave. It lasts exactly one cycle.
- Owner dropping CYC/STB while the slave is busy: a late `S_ACK_I` after the release is not forwarded to either master.
- Simultaneous release and new request by the same master: the other master wins if it is requesting (fairness). Otherwise the same master is re-granted via IDLE, one idle cycle later.

## Test plan
- Single master write: M0 writes addr 0x01, data 0x4154A000; slave ACKs 2 cycles later.
  - Required: `GNT_O` = 01 one edge after CYC; `S_ADR_O` = 0x01, `S_DAT_O` = 0x4154A000;
  - `M0_ACK_O` pulses; `M1_ACK_O` stays 0.
- Contention after reset: both CYC rise on the same edge.
  - Required: M0 served first (`ptr` = 0).
  - When M0 drops CYC, `GNT_O` = 10 on the next edge with no IDLE cycle; M1 reads addr 0x02 and gets `S_DAT_I` value 0x0000A5A5 with `M1_ACK_O`.
- Fairness: both masters keep re-requesting for 6 transfers.
  - Required: grants alternate 01, 10, 01, 10, 01, 10.
- Watchdog: TIMEOUT = 16, slave never ACKs, M0 holds STB.
  - Required: `M0_ERR_O` = 1 for exactly one cycle 17 cycles after the slave sees STB; `S_STB_O` = 0 in that cycle; no ACK.
  - With TIMEOUT = 0: no ERR after 1000 cycles.
- Reset mid-access: assert `RST_I` between clock edges while M1 owns the bus.
  - Required: `GNT_O`/`S_CYC_O`/`S_STB_O` go to 0 immediately, before the next edge.
  - After release: M0 and M1 both requesting → M0 granted.
- Abandoned access: M1 drops CYC/STB while waiting; slave ACKs one cycle later.
  - Required: neither `M0_ACK_O` nor `M1_ACK_O` asserts; `GNT_O` = 00 after the release edge.

Source files
------------

// File: rtl/wb_spi_arbiter.sv
// Two-master Wishbone arbiter in front of the SPI bridge slave: round-robin, grant held per CYC.
// Latency: grant registered one edge after CYC; slave-side routing and ACK are combinational.
// Backpressure: slave stalls pass straight through; a watchdog aborts an unacknowledged STB with ERR.
module wb_spi_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  input  logic        M0_WE_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  output logic [31:0] M0_DAT_O,
  output logic        M0_ACK_O,
  output logic        M0_ERR_O,
  input  logic [7:0]  M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  input  logic        M1_WE_I,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  output logic [31:0] M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        M1_ERR_O,
  output logic [7:0]  S_ADR_O,
  output logic [31:0] S_DAT_O,
  output logic        S_WE_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  input  logic [31:0] S_DAT_I,
  input  logic        S_ACK_I,
  output logic [1:0]  GNT_O
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

  // Watchdog compare value; a zero TIMEOUT disables the watchdog entirely.
  localparam bit            WD_EN     = (TIMEOUT != 0);
  localparam int            TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ptr;
  logic            w_ptr_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic            r_abort;
  logic            w_abort_nxt;
  logic            w_sel0;
  logic            w_sel1;
  logic            w_own_stb;

  // State, preference pointer, watchdog counter and abort flag registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 1'b0;
      r_to_cnt <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_to_cnt <= w_cnt_nxt;
      r_abort  <= w_abort_nxt;
    end
  end

  // Round-robin arbitration: release hands over directly when the other master waits.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (M0_CYC_I && M1_CYC_I) w_state_nxt = r_ptr ? ST_OWN1 : ST_OWN0;
        else if (M0_CYC_I)        w_state_nxt = ST_OWN0;
        else if (M1_CYC_I)        w_state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!M0_CYC_I) begin
          w_ptr_nxt   = 1'b1;
          w_state_nxt = M1_CYC_I ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!M1_CYC_I) begin
          w_ptr_nxt   = 1'b0;
          w_state_nxt = M0_CYC_I ? ST_OWN0 : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Owner decode and the owner's strobe, shared by routing and the watchdog.
  always_comb begin
    w_sel0    = (r_state == ST_OWN0);
    w_sel1    = (r_state == ST_OWN1);
    w_own_stb = (w_sel0 & M0_STB_I) | (w_sel1 & M1_STB_I);
  end

  // Watchdog: count stalled strobe cycles; any handover, ACK or idle strobe restarts it.
  always_comb begin
    w_cnt_nxt   = '0;
    w_abort_nxt = 1'b0;
    if (WD_EN && (r_state != ST_IDLE) && (w_state_nxt == r_state) &&
        !r_abort && w_own_stb && !S_ACK_I) begin
      if (r_to_cnt == TO_LAST) w_abort_nxt = 1'b1;
      else                     w_cnt_nxt   = r_to_cnt + TO_W'(1);
    end
  end

  // Slave-side routing from the current owner; all zero when idle, strobe masked on abort.
  always_comb begin
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_WE_O  = 1'b0;
    S_CYC_O = 1'b0;
    if (w_sel0) begin
      S_ADR_O = M0_ADR_I;
      S_DAT_O = M0_DAT_I;
      S_WE_O  = M0_WE_I;
      S_CYC_O = M0_CYC_I;
    end else if (w_sel1) begin
      S_ADR_O = M1_ADR_I;
      S_DAT_O = M1_DAT_I;
      S_WE_O  = M1_WE_I;
      S_CYC_O = M1_CYC_I;
    end
    S_STB_O = w_own_stb & ~r_abort;
  end

  // Master-side responses: ACK/ERR only to the owner, read data broadcast.
  always_comb begin
    M0_DAT_O = S_DAT_I;
    M1_DAT_O = S_DAT_I;
    M0_ACK_O = S_ACK_I & M0_STB_I & w_sel0 & ~r_abort;
    M1_ACK_O = S_ACK_I & M1_STB_I & w_sel1 & ~r_abort;
    M0_ERR_O = r_abort & w_sel0;
    M1_ERR_O = r_abort & w_sel1;
    GNT_O    = {w_sel1, w_sel0};
  end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Directed bench for wb_spi_arbiter: grant, handover, fairness, watchdog, reset, abandoned access.
// A second instance with the watchdog disabled shares all inputs.
// Outputs are sampled 1-2 ns after the rising edge, inputs driven at +1 ns.
module tb_wb_spi_arbiter;

  logic        CLK_I;
  logic        RST_I;
  logic [7:0]  M0_ADR_I, M1_ADR_I;
  logic [31:0] M0_DAT_I, M1_DAT_I;
  logic        M0_WE_I, M1_WE_I, M0_CYC_I, M1_CYC_I, M0_STB_I, M1_STB_I;
  logic [31:0] M0_DAT_O, M1_DAT_O;
  logic        M0_ACK_O, M1_ACK_O, M0_ERR_O, M1_ERR_O;
  logic [7:0]  S_ADR_O;
  logic [31:0] S_DAT_O;
  logic        S_WE_O, S_CYC_O, S_STB_O;
  logic [31:0] S_DAT_I;
  logic        S_ACK_I;
  logic [1:0]  GNT_O;

  // Outputs of the watchdog-disabled instance.
  logic [31:0] z_m0_dat, z_m1_dat, z_s_dat;
  logic        z_m0_ack, z_m1_ack, z_m0_err, z_m1_err;
  logic [7:0]  z_s_adr;
  logic        z_s_we, z_s_cyc, z_s_stb;
  logic [1:0]  z_gnt;

  int n_checks = 0;
  int n_errors = 0;

  wb_spi_arbiter #(.TIMEOUT(16), .TO_W(8)) u_dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_WE_I(M0_WE_I), .M0_CYC_I(M0_CYC_I),
    .M0_STB_I(M0_STB_I), .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
    .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_WE_I(M1_WE_I), .M1_CYC_I(M1_CYC_I),
    .M1_STB_I(M1_STB_I), .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_WE_O(S_WE_O), .S_CYC_O(S_CYC_O),
    .S_STB_O(S_STB_O), .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I), .GNT_O(GNT_O)
  );

  wb_spi_arbiter #(.TIMEOUT(0), .TO_W(8)) u_dut_nowd (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_WE_I(M0_WE_I), .M0_CYC_I(M0_CYC_I),
    .M0_STB_I(M0_STB_I), .M0_DAT_O(z_m0_dat), .M0_ACK_O(z_m0_ack), .M0_ERR_O(z_m0_err),
    .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_WE_I(M1_WE_I), .M1_CYC_I(M1_CYC_I),
    .M1_STB_I(M1_STB_I), .M1_DAT_O(z_m1_dat), .M1_ACK_O(z_m1_ack), .M1_ERR_O(z_m1_err),
    .S_ADR_O(z_s_adr), .S_DAT_O(z_s_dat), .S_WE_O(z_s_we), .S_CYC_O(z_s_cyc),
    .S_STB_O(z_s_stb), .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I), .GNT_O(z_gnt)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic m0_drive(input logic cyc, input logic stb, input logic we,
                          input logic [7:0] adr, input logic [31:0] dat);
    M0_CYC_I = cyc; M0_STB_I = stb; M0_WE_I = we; M0_ADR_I = adr; M0_DAT_I = dat;
  endtask

  task automatic m1_drive(input logic cyc, input logic stb, input logic we,
                          input logic [7:0] adr, input logic [31:0] dat);
    M1_CYC_I = cyc; M1_STB_I = stb; M1_WE_I = we; M1_ADR_I = adr; M1_DAT_I = dat;
  endtask

  // Reset pulse placed between edges.
  task automatic pulse_reset();
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    RST_I = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_gnt;
    int         err_cnt;

    RST_I   = 1'b1;
    S_ACK_I = 1'b0;
    S_DAT_I = 32'h1234_5678;
    m0_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    m1_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    #2;
    // Reset state.
    chk_eq("rst_gnt",   32'(GNT_O),    32'h0);
    chk_eq("rst_s_cyc", 32'(S_CYC_O),  32'h0);
    chk_eq("rst_s_stb", 32'(S_STB_O),  32'h0);
    chk_eq("rst_s_adr", 32'(S_ADR_O),  32'h0);
    chk_eq("rst_acks",  32'({M0_ACK_O, M1_ACK_O, M0_ERR_O, M1_ERR_O}), 32'h0);
    chk_eq("rst_m0_dat", M0_DAT_O, 32'h1234_5678);
    chk_eq("rst_m1_dat", M1_DAT_O, 32'h1234_5678);
    @(negedge CLK_I);
    RST_I = 1'b0;

    // Single master write.
    step();
    m0_drive(1'b1, 1'b1, 1'b1, 8'h01, 32'h4154_A000);
    settle();
    chk_eq("w_gnt_before", 32'(GNT_O), 32'h0);
    step();
    chk_eq("w_gnt",   32'(GNT_O),   32'h1);
    chk_eq("w_s_adr", 32'(S_ADR_O), 32'h01);
    chk_eq("w_s_dat", S_DAT_O,      32'h4154_A000);
    chk_eq("w_s_we_stb", 32'({S_WE_O, S_CYC_O, S_STB_O}), 32'h7);
    chk_eq("w_noack_early", 32'(M0_ACK_O), 32'h0);
    step();
    step();
    S_ACK_I = 1'b1;
    settle();
    chk_eq("w_m0_ack", 32'(M0_ACK_O), 32'h1);
    chk_eq("w_m1_ack", 32'(M1_ACK_O), 32'h0);
    step();
    S_ACK_I = 1'b0;
    m0_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    settle();
    chk_eq("w_ack_drop", 32'(M0_ACK_O), 32'h0);
    step();
    chk_eq("w_gnt_idle", 32'(GNT_O), 32'h0);

    // Contention right after reset: M0 first, then M1 with no idle gap.
    pulse_reset();
    m0_drive(1'b1, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
    m1_drive(1'b1, 1'b1, 1'b0, 8'h02, 32'h0);
    step();
    chk_eq("c_gnt_m0", 32'(GNT_O),   32'h1);
    chk_eq("c_s_adr0", 32'(S_ADR_O), 32'h10);
    S_ACK_I = 1'b1;
    settle();
    chk_eq("c_m0_ack", 32'(M0_ACK_O), 32'h1);
    chk_eq("c_m1_ack_no", 32'(M1_ACK_O), 32'h0);
    step();
    S_ACK_I = 1'b0;
    m0_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk_eq("c_gnt_m1", 32'(GNT_O), 32'h2);
    chk_eq("c_s_adr1", 32'(S_ADR_O), 32'h02);
    chk_eq("c_s_we1",  32'(S_WE_O),  32'h0);
    S_DAT_I = 32'h0000_A5A5;
    S_ACK_I = 1'b1;
    settle();
    chk_eq("c_m1_ack", 32'(M1_ACK_O), 32'h1);
    chk_eq("c_m1_dat", M1_DAT_O,      32'h0000_A5A5);
    chk_eq("c_m0_ack_no", 32'(M0_ACK_O), 32'h0);
    step();
    S_ACK_I = 1'b0;
    m1_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk_eq("c_gnt_idle", 32'(GNT_O), 32'h0);

    // Fairness: both keep re-requesting; M1 released last so M0 is preferred.
    m0_drive(1'b1, 1'b1, 1'b1, 8'h20, 32'h0);
    m1_drive(1'b1, 1'b1, 1'b0, 8'h21, 32'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk_eq($sformatf("fair_gnt%0d", i), 32'(GNT_O), 32'(exp_gnt));
      S_ACK_I = 1'b1;
      step();
      S_ACK_I = 1'b0;
      if (exp_gnt == 2'b01) m0_drive(1'b0, 1'b0, 1'b1, 8'h20, 32'h0);
      else                  m1_drive(1'b0, 1'b0, 1'b0, 8'h21, 32'h0);
      step();
      if (exp_gnt == 2'b01) m0_drive(1'b1, 1'b1, 1'b1, 8'h20, 32'h0);
      else                  m1_drive(1'b1, 1'b1, 1'b0, 8'h21, 32'h0);
    end
    m0_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    m1_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    step();
    chk_eq("fair_idle", 32'(GNT_O), 32'h0);

    // Watchdog: M0 strobes, slave never answers.
    m0_drive(1'b1, 1'b1, 1'b0, 8'h30, 32'h0);
    step();
    chk_eq("wd_gnt", 32'(GNT_O), 32'h1);
    for (int i = 0; i < 15; i++) step();
    chk_eq("wd_err_early", 32'(M0_ERR_O), 32'h0);
    chk_eq("wd_stb_early", 32'(S_STB_O),  32'h1);
    step();
    S_ACK_I = 1'b1;
    settle();
    chk_eq("wd_err",      32'(M0_ERR_O), 32'h1);
    chk_eq("wd_stb_mask", 32'(S_STB_O),  32'h0);
    chk_eq("wd_ack_drop", 32'(M0_ACK_O), 32'h0);
    chk_eq("wd_m1_err",   32'(M1_ERR_O), 32'h0);
    S_ACK_I = 1'b0;
    step();
    chk_eq("wd_err_end", 32'(M0_ERR_O), 32'h0);
    chk_eq("wd_gnt_kept", 32'(GNT_O),   32'h1);
    chk_eq("wd_stb_back", 32'(S_STB_O), 32'h1);
    // Disabled watchdog instance stays silent over a long stall.
    err_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (z_m0_err || z_m1_err) err_cnt++;
    end
    chk_eq("wd0_no_err", 32'(err_cnt), 32'h0);
    m0_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    step();

    // Reset in the middle of an M1 access.
    m1_drive(1'b1, 1'b1, 1'b1, 8'h40, 32'h5555_AAAA);
    step();
    chk_eq("rm_gnt_m1", 32'(GNT_O), 32'h2);
    #3;
    RST_I = 1'b1;
    #1;
    chk_eq("rm_gnt",   32'(GNT_O),   32'h0);
    chk_eq("rm_s_cyc", 32'(S_CYC_O), 32'h0);
    chk_eq("rm_s_stb", 32'(S_STB_O), 32'h0);
    m0_drive(1'b1, 1'b1, 1'b0, 8'h41, 32'h0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    step();
    chk_eq("rm_regrant_m0", 32'(GNT_O), 32'h1);
    m0_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    m1_drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    step();

    // Abandoned access: late ACK is forwarded to nobody.
    m1_drive(1'b1, 1'b1, 1'b0, 8'h50, 32'h0);
    step();
    chk_eq("ab_gnt_m1", 32'(GNT_O), 32'h2);
    step();
    m1_drive(1'b0, 1'b0, 1'b0, 8'h50, 32'h0);
    settle();
    chk_eq("ab_m1_ack0", 32'(M1_ACK_O), 32'h0);
    step();
    S_ACK_I = 1'b1;
    settle();
    chk_eq("ab_gnt_idle", 32'(GNT_O), 32'h0);
    chk_eq("ab_acks", 32'({M0_ACK_O, M1_ACK_O}), 32'h0);
    S_ACK_I = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
